// File: rtl/register_file.sv
// 32 x 32-bit general-purpose register file: two combinational read ports and
// one synchronous write port. Register 0 is hardwired to zero.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];

  // Writes to index 0 are dropped so that entry stays at its reset value of 0.
  always_comb begin
    regs_d = regs_q;
    if (RegWrite && (WriteRegister != '0)) begin
      regs_d[WriteRegister] = WriteData;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: a same-index read shows the new value only after the edge.
  assign ReadData1 = (ReadRegister1 == '0) ? '0 : regs_q[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == '0) ? '0 : regs_q[ReadRegister2];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a plain array model checked every falling
// edge, plus hand-computed literal expectations for each scenario.
module tb_register_file;

  logic        Clk;
  logic        Rst;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] model [32];

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  end

  // Model: reset clears everything at once; enabled writes land on the rising edge.
  always @(negedge Rst) begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  end

  always @(posedge Clk) begin
    if (Rst === 1'b1 && RegWrite === 1'b1 && WriteRegister != 5'd0)
      model[WriteRegister] = WriteData;
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (Rst === 1'b0) ? 32'h0 : model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("model_rd1", ReadData1, model_read(ReadRegister1));
      check("model_rd2", ReadData2, model_read(ReadRegister2));
    end
  end

  initial begin
    Rst = 1'b1;
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    WriteRegister = 5'd0;
    WriteData     = 32'h0;
    RegWrite      = 1'b0;
    #2;

    // Reset held while attempting a write to reg 5
    Rst = 1'b0;
    #1;
    cmp_en = 1'b1;
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'h0000FFFF;
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
    repeat (3) @(posedge Clk);
    #2;
    check("reset_hold_rd1_r5", ReadData1, 32'h0);
    RegWrite = 1'b0;
    @(posedge Clk); #4;
    Rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      #1;
      check("post_reset_rd1", ReadData1, 32'h0);
      check("post_reset_rd2", ReadData2, 32'h0);
    end

    // Bulk writes, one register per 100 ns
    @(posedge Clk); #4;
    RegWrite = 1'b1;
    for (int i = 8; i <= 24; i++) begin
      WriteRegister = 5'(i);
      WriteData     = 32'(i * 3);
      repeat (5) @(posedge Clk);
      #4;
    end
    RegWrite = 1'b0;

    for (int i = 8; i <= 24; i += 2) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(i + 1);
      #2;
      check("pair_rd1", ReadData1, 32'(3 * i));
      check("pair_rd2", ReadData2, (i + 1 <= 24) ? 32'(3 * (i + 1)) : 32'h0);
    end
    ReadRegister1 = 5'd8; ReadRegister2 = 5'd9; #1;
    check("pair_8_9_a", ReadData1, 32'd24);
    check("pair_8_9_b", ReadData2, 32'd27);
    ReadRegister1 = 5'd22; ReadRegister2 = 5'd23; #1;
    check("pair_22_23_a", ReadData1, 32'd66);
    check("pair_22_23_b", ReadData2, 32'd69);
    ReadRegister1 = 5'd24; ReadRegister2 = 5'd25; #1;
    check("pair_24_25_a", ReadData1, 32'd72);
    check("pair_24_25_b", ReadData2, 32'd0);

    // Writes to register 0 are discarded
    @(posedge Clk); #4;
    RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hDEADBEEF;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    repeat (2) @(posedge Clk);
    #1;
    check("reg0_rd1", ReadData1, 32'h0);
    check("reg0_rd2", ReadData2, 32'h0);

    // Write disabled over several edges
    #3;
    RegWrite = 1'b0; WriteRegister = 5'd8; WriteData = 32'h1234;
    ReadRegister1 = 5'd8; ReadRegister2 = 5'd8;
    repeat (4) @(posedge Clk);
    #1;
    check("wr_disable_r8_a", ReadData1, 32'd24);
    check("wr_disable_r8_b", ReadData2, 32'd24);

    // Read-during-write to the same index
    #3;
    ReadRegister1 = 5'd10; ReadRegister2 = 5'd11;
    RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 32'hABCD;
    #2;
    check("rdw_before_edge", ReadData1, 32'd30);
    @(posedge Clk);
    #1;
    check("rdw_after_edge", ReadData1, 32'hABCD);
    check("rdw_other_port", ReadData2, 32'd33);
    #3;
    RegWrite = 1'b0;

    // Short asynchronous reset pulse between edges
    @(posedge Clk); #5;
    ReadRegister1 = 5'd8; ReadRegister2 = 5'd24;
    #1;
    check("pre_async_rd1", ReadData1, 32'd24);
    Rst = 1'b0;
    #1;
    check("async_rst_rd1", ReadData1, 32'h0);
    check("async_rst_rd2", ReadData2, 32'h0);
    #2;
    Rst = 1'b1;
    #1;
    check("after_async_rd1", ReadData1, 32'h0);
    check("after_async_rd2", ReadData2, 32'h0);

    // Fresh write after the pulse, with both ports on the same index
    @(posedge Clk); #4;
    RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 32'h8000_0001;
    ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
    @(posedge Clk); #4;
    RegWrite = 1'b0;
    check("same_idx_rd1", ReadData1, 32'h8000_0001);
    check("same_idx_rd2", ReadData2, 32'h8000_0001);
    repeat (2) @(posedge Clk);
    #1;

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
